chmux_scan: RTL and testbench
=============================

Name: chmux_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; successor of the combinational 4:1 2-bit mux.
- Adds a manual-select mode and an auto-scan mode that steps round-robin through channels with a programmable dwell time.
- Adds sample-and-hold and a channel-change strobe.
- Sits between board inputs (switches/sensor words) and display/LED drivers.

Parameters:
- WIDTH, 2, bits per channel (>=1)
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, selector width; must satisfy 2**SEL_W >= CHANNELS
- DWELL, 4, clock cycles spent on each channel in scan mode (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- sel_in  in  SEL_W  manual channel select
- mode  in  1  0 = manual, 1 = auto-scan
- hold  in  1  1 = freeze channel, dwell counter and dout
- dout  out  WIDTH  registered selected data
- ch_out  out  SEL_W  channel index that produced the current dout
- ch_changed  out  1  one-cycle pulse when ch_out changes value

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are clk and rst.
- Reset values: dout=0, ch_out=0, ch_changed=0, dwell counter cnt=0.
- Every rising edge with hold=0:
  - compute ch_next;
  - ch_out <= ch_next;
  - dout <= din slice of ch_next;
  - ch_changed <= (ch_next != ch_out).
  - dout and ch_out are always mutually consistent.
- Latency: exactly 1 cycle from din/sel_in change to dout.
- Manual mode (mode=0):
  - ch_next = sel_in if sel_in < CHANNELS; otherwise ch_next = ch_out (out-of-range select is ignored).
  - cnt held at 0.
- Scan mode (mode=1):
  - cnt increments each cycle.
  - When cnt == DWELL-1: cnt <= 0 and ch_next = ch_out+1, wrapping CHANNELS-1 -> 0. Otherwise ch_next = ch_out.
  - DWELL=1 advances the channel every cycle.
  - Counter width is max(1, clog2(DWELL)).
- Mode change manual -> scan: scan starts from the current ch_out with cnt=0. The first advance comes DWELL cycles after mode goes high.
- Mode change scan -> manual: sel_in takes effect on the same edge that first samples mode=0. cnt clears to 0.
- Hold:
  - hold=1 freezes ch_out, dout (sample-and-hold) and cnt.
  - ch_changed is forced to 0 while hold=1.
  - Releasing hold resumes with the frozen cnt; no dwell cycles are lost or added.
- Simultaneous hold=1 and mode change: hold wins. The mode change is acted on at the first edge after hold deasserts.
- rst asserted mid-scan: all state returns to reset values immediately (asynchronous). Scanning restarts from channel 0 after release.

Optional Feature:
- Macro: CHMUX_SKIP_MASK_EN.
- When defined:
  - Extra input port ch_mask (in, CHANNELS bits); bit k=1 enables channel k.
  - Scan advance moves to the next enabled channel in ascending order with wrap.
  - If the current channel becomes disabled, the next advance still searches from ch_out+1.
  - All-zero mask: ch_out and dout hold their values and ch_changed stays 0.
  - Manual select of a disabled channel is ignored, like an out-of-range select.
- When undefined: the port is absent and all channels are enabled; behaviour is exactly as above.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> dout=0, ch_out=0 and ch_changed=0 before the next edge.
- Manual select, CHANNELS=4, WIDTH=2, din = {ch3=2'b11, ch2=2'b10, ch1=2'b01, ch0=2'b00}:
  - stimulus: sel_in=2 -> next edge: dout=2'b10, ch_out=2, ch_changed=1 for 1 cycle;
  - then sel_in=2 held -> ch_changed=0.
- Out-of-range select, CHANNELS=3, SEL_W=2: sel_in=3 -> ch_out and dout unchanged, ch_changed=0.
- Scan, DWELL=3, mode=1 from ch_out=0 -> ch_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; ch_changed pulses at each transition including the 3->0 wrap.
- Hold mid-dwell: hold=1 for 5 cycles at cnt=1 on ch 2; din ch2 changes meanwhile -> dout frozen. After release, ch 2 lasts exactly 2 more cycles.
- Mask (CHMUX_SKIP_MASK_EN defined), ch_mask=4'b1010, DWELL=1 -> ch_out sequence 1,3,1,3. Then ch_mask=0 -> ch_out and dout frozen, ch_changed=0.

Source files
------------

// File: rtl/chmux_scan.sv
// chmux_scan: registered N-channel, W-bit multiplexer with manual select, round-robin
// auto-scan (programmable dwell), sample-and-hold and a one-cycle channel-change strobe.
// Latency: 1 cycle from din/sel_in to dout. Optional macro CHMUX_SKIP_MASK_EN adds ch_mask.
module chmux_scan #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode,
  input  logic                      hold,
`ifdef CHMUX_SKIP_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          ch_out,
  output logic                      ch_changed
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CHANNELS-1:0] en;
  logic                any_en;

  logic [SEL_W-1:0]    ch_q, ch_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                chg_q, chg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                sel_ok;
  logic [SEL_W-1:0]    scan_nxt;
  logic [WIDTH-1:0]    sel_dat;

`ifdef CHMUX_SKIP_MASK_EN
  assign en = ch_mask;
`else
  assign en = {CHANNELS{1'b1}};
`endif

  // With no channel enabled there is nothing valid to show, so outputs freeze.
  assign any_en = |en;

  // Manual select is accepted only for an existing, enabled channel.
  always_comb begin
    sel_ok = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_in == SEL_W'(k)) sel_ok = en[k];
    end
  end

  // Next enabled channel above ch_q, else wrap to the lowest enabled one (may be ch_q itself).
  always_comb begin
    logic             found_hi;
    logic             found_any;
    logic [SEL_W-1:0] nxt_hi;
    logic [SEL_W-1:0] nxt_min;
    found_hi  = 1'b0;
    found_any = 1'b0;
    nxt_hi    = ch_q;
    nxt_min   = ch_q;
    // Descending walk: the last hit is the smallest qualifying index.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (en[k]) begin
        found_any = 1'b1;
        nxt_min   = SEL_W'(k);
        if (SEL_W'(k) > ch_q) begin
          found_hi = 1'b1;
          nxt_hi   = SEL_W'(k);
        end
      end
    end
    if (found_hi)       scan_nxt = nxt_hi;
    else if (found_any) scan_nxt = nxt_min;
    else                scan_nxt = ch_q;
  end

  // Channel / dwell-counter next state; hold freezes both and suppresses the strobe.
  always_comb begin
    ch_d  = ch_q;
    cnt_d = cnt_q;
    chg_d = 1'b0;
    if (!hold) begin
      if (mode) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          ch_d  = scan_nxt;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        // Manual mode keeps the counter at zero so a later scan starts a full dwell.
        cnt_d = '0;
        if (sel_ok) ch_d = sel_in;
      end
      chg_d = (ch_d != ch_q);
    end
  end

  // Data slice for the channel about to be registered, so dout always matches ch_out.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_d == SEL_W'(k)) sel_dat = din[k*WIDTH +: WIDTH];
    end
  end

  // Sample-and-hold: dout only follows din when not held and some channel is enabled.
  always_comb begin
    dout_d = dout_q;
    if (!hold && any_en) dout_d = sel_dat;
  end

  // State registers with asynchronous reset to channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q   <= '0;
      dout_q <= '0;
      chg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ch_q   <= ch_d;
      dout_q <= dout_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign ch_out     = ch_q;
  assign ch_changed = chg_q;

endmodule

// File: tb/tb_chmux_scan.sv
// Scoreboard bench for chmux_scan: directed rows push expected outputs into a queue,
// a monitor pops one entry per clock and compares against the addressed DUT instance.
module tb_chmux_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din4;
  logic [5:0] din3;
  logic [1:0] sel;
  logic       mode;
  logic       hold;

  logic [1:0] dout4, ch4, dout3, ch3;
  logic       chg4, chg3;

`ifdef CHMUX_SKIP_MASK_EN
  logic [3:0] mask4;
  logic [2:0] mask3;
  logic [3:0] mask_m;
  logic [1:0] sel_m;
  logic       mode_m;
  logic       hold_m;
  logic [1:0] doutm, chm;
  logic       chgm;
`endif

  always #5 clk = ~clk;

  // 4 channels, dwell 3
  chmux_scan #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .DWELL(3)) u_dut4 (
    .clk(clk), .rst(rst), .din(din4), .sel_in(sel), .mode(mode), .hold(hold),
`ifdef CHMUX_SKIP_MASK_EN
    .ch_mask(mask4),
`endif
    .dout(dout4), .ch_out(ch4), .ch_changed(chg4));

  // 3 channels on a 2-bit selector: sel_in=3 is out of range
  chmux_scan #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .DWELL(3)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel_in(sel), .mode(mode), .hold(hold),
`ifdef CHMUX_SKIP_MASK_EN
    .ch_mask(mask3),
`endif
    .dout(dout3), .ch_out(ch3), .ch_changed(chg3));

`ifdef CHMUX_SKIP_MASK_EN
  // 4 channels, dwell 1, independent controls for the mask scenarios
  chmux_scan #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .DWELL(1)) u_dutm (
    .clk(clk), .rst(rst), .din(din4), .sel_in(sel_m), .mode(mode_m), .hold(hold_m),
    .ch_mask(mask_m),
    .dout(doutm), .ch_out(chm), .ch_changed(chgm));
`endif

  typedef struct {
    int         dut;
    logic [1:0] d;
    logic [1:0] c;
    logic       g;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [1:0] ad, input logic [1:0] ac, input logic ag,
                     input logic [1:0] ed, input logic [1:0] ec, input logic eg);
    checks++;
    if (ad !== ed || ac !== ec || ag !== eg) begin
      errors++;
      $display("FAIL %s: got dout=%0d ch_out=%0d ch_changed=%0d, want dout=%0d ch_out=%0d ch_changed=%0d",
               nm, ad, ac, ag, ed, ec, eg);
    end
  endtask

  // Drive one row at a falling edge, queue what the next rising edge must produce.
  task automatic step(input string nm, input int dut, input logic [1:0] s,
                      input logic m, input logic h,
                      input logic [1:0] ed, input logic [1:0] ec, input logic eg);
    exp_t e;
    sel  = s;
    mode = m;
    hold = h;
    e.dut = dut; e.d = ed; e.c = ec; e.g = eg; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expectation is consumed per rising edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        case (e.dut)
          0: chk(e.nm, dout4, ch4, chg4, e.d, e.c, e.g);
          1: chk(e.nm, dout3, ch3, chg3, e.d, e.c, e.g);
`ifdef CHMUX_SKIP_MASK_EN
          2: chk(e.nm, doutm, chm, chgm, e.d, e.c, e.g);
`endif
          default: begin
            checks++;
            errors++;
            $display("FAIL %s: unknown instance id %0d", e.nm, e.dut);
          end
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scan sequence from ch 0 with dwell 3 (din4 = E4 so dout equals channel index),
  // continued until ch 2 has cnt=1.
  logic [1:0] sc_ch  [19];
  logic       sc_chg [19];

  initial begin
    sc_ch  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0,
               2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    sc_chg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst  = 1'b1;
    din4 = 8'hE4;              // ch3=3 ch2=2 ch1=1 ch0=0
    din3 = 6'b10_01_11;        // ch2=2 ch1=1 ch0=3
    sel  = 2'd0;
    mode = 1'b0;
    hold = 1'b0;
`ifdef CHMUX_SKIP_MASK_EN
    mask4  = 4'hF;
    mask3  = 3'b111;
    mask_m = 4'b1010;
    sel_m  = 2'd0;
    mode_m = 1'b0;
    hold_m = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset4", dout4, ch4, chg4, 2'd0, 2'd0, 1'b0);
    chk("reset3", dout3, ch3, chg3, 2'd0, 2'd0, 1'b0);
    rst = 1'b0;

    // Manual select on the 4-channel instance
    step("sel2",      0, 2'd2, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1);
    step("sel2_held", 0, 2'd2, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0);
    step("sel1",      0, 2'd1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
    din4 = 8'b11_10_10_00;     // ch1 data changes to 2
    step("din_lat",   0, 2'd1, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0);
    din4 = 8'hE4;

    // Out-of-range select on the 3-channel instance (currently ch1)
    step("s3_sel0",   1, 2'd0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1);
    step("s3_oor",    1, 2'd3, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
    step("s3_oor2",   1, 2'd3, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
    step("s3_sel2",   1, 2'd2, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1);
    step("s3_oor3",   1, 2'd3, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0);

    // 4-channel instance sits on ch3 here; return to ch0, then scan
    step("scan_pre",  0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    for (int i = 0; i < 19; i++)
      step($sformatf("scan%0d", i), 0, 2'd1, 1'b1, 1'b0, sc_ch[i], sc_ch[i], sc_chg[i]);

    // Hold 5 cycles on ch2 at cnt=1 while ch2 data changes
    din4 = 8'b11_01_01_00;
    for (int i = 0; i < 5; i++)
      step($sformatf("hold%0d", i), 0, 2'd1, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0);
    step("rel1",      0, 2'd1, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0);
    step("rel2",      0, 2'd1, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1);

    // Mode drop while held: acted on only after hold releases
    step("hold_mode1", 0, 2'd1, 1'b0, 1'b1, 2'd3, 2'd3, 1'b0);
    step("hold_mode2", 0, 2'd1, 1'b0, 1'b1, 2'd3, 2'd3, 1'b0);
    step("mode_after", 0, 2'd1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);

    // Manual -> scan: first advance after a full dwell
    step("m2s_a",     0, 2'd1, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0);
    step("m2s_b",     0, 2'd1, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0);
    step("m2s_c",     0, 2'd1, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1);
    step("s_mid",     0, 2'd1, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0);
    // Scan -> manual: sel_in applies on the same edge, cnt clears
    step("s2m",       0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    step("rescan_a",  0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    step("rescan_b",  0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    step("rescan_c",  0, 2'd0, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1);

    // Asynchronous reset mid-cycle during scan
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst4", dout4, ch4, chg4, 2'd0, 2'd0, 1'b0);
    chk("async_rst3", dout3, ch3, chg3, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst0", 0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    step("post_rst1", 0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    step("post_rst2", 0, 2'd1, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1);

`ifdef CHMUX_SKIP_MASK_EN
    // Mask 1010, dwell 1: 1,3,1,3
    din4   = 8'hE4;
    sel    = 2'd0;
    mode   = 1'b0;
    mode_m = 1'b1;
    step("mask_a",    2, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
    step("mask_b",    2, 2'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1);
    step("mask_c",    2, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
    step("mask_d",    2, 2'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1);
    // All-zero mask freezes channel and data
    mask_m = 4'b0000;
    din4   = 8'b00_10_01_00;
    step("mask0_a",   2, 2'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0);
    step("mask0_b",   2, 2'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0);
    // Manual select of a disabled channel is ignored
    mask_m = 4'b1010;
    din4   = 8'hE4;
    mode_m = 1'b0;
    sel_m  = 2'd0;
    step("mask_seldis", 2, 2'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0);
    sel_m  = 2'd1;
    step("mask_sel1",   2, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
    // Current channel disabled: search still starts above it
    mask_m = 4'b1001;
    mode_m = 1'b1;
    step("mask_skip_a", 2, 2'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1);
    step("mask_skip_b", 2, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
`endif

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
